// File: rtl/test_pattern_checker.sv
// Incrementing-counter pattern checker: hunts for lock, then counts words and mismatches.
// Latency: every output is registered and reflects a consumed sample on the following cycle.
// Backpressure: none; the checker accepts every valid word. TPC_CNT_SAT_EN makes the counters saturate.
module test_pattern_checker #(
    parameter int WIDTH      = 10,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_d,
    input  logic                 i_clear,
    output logic                 o_locked,
    output logic                 o_err,
    output logic                 o_err_sticky,
    output logic [CNT_WIDTH-1:0] o_word_count,
    output logic [CNT_WIDTH-1:0] o_err_count
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]           LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0]           UNLOCK_LAST = 8'(UNLOCK_CNT - 1);
    localparam logic [WIDTH-1:0]     D_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 seeded_q, seeded_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [7:0]           run_q, run_d;
    logic [7:0]           bad_q, bad_d;
    logic                 err_q, err_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 match;

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
`ifdef TPC_CNT_SAT_EN
        cnt_inc = (&c) ? c : c + C_ONE;
`else
        cnt_inc = c + C_ONE;
`endif
    endfunction

    always_comb begin
        state_d    = state_q;
        seeded_d   = seeded_q;
        exp_d      = exp_q;
        run_d      = run_q;
        bad_d      = bad_q;
        err_d      = 1'b0;
        sticky_d   = sticky_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        match      = (i_d == exp_q);

        if (i_clear) begin
            state_d    = ST_HUNT;
            seeded_d   = 1'b0;
            exp_d      = '0;
            run_d      = '0;
            bad_d      = '0;
            sticky_d   = 1'b0;
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (i_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // HUNT re-seeds from every word so a single glitch only restarts the run.
                    exp_d = i_d + D_ONE;
                    if (!seeded_q) begin
                        seeded_d = 1'b1;
                    end else if (!match) begin
                        run_d = '0;
                    end else if (run_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                        bad_d   = '0;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
                default: begin
                    // LOCKED free-runs the expectation so one bad word costs exactly one error.
                    exp_d      = exp_q + D_ONE;
                    word_cnt_d = cnt_inc(word_cnt_q);
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        sticky_d  = 1'b1;
                        err_cnt_d = cnt_inc(err_cnt_q);
                        if (bad_q == UNLOCK_LAST) begin
                            state_d  = ST_HUNT;
                            seeded_d = 1'b0;
                            run_d    = '0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_HUNT;
            seeded_q   <= 1'b0;
            exp_q      <= '0;
            run_q      <= '0;
            bad_q      <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            seeded_q   <= seeded_d;
            exp_q      <= exp_d;
            run_q      <= run_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_locked     = (state_q == ST_LOCKED);
    assign o_err        = err_q;
    assign o_err_sticky = sticky_q;
    assign o_word_count = word_cnt_q;
    assign o_err_count  = err_cnt_q;

endmodule

// File: tb/tb_test_pattern_checker.sv
// Bench for test_pattern_checker: a default-width instance plus a CNT_WIDTH=2 instance on shared stimulus.
// A behavioural model feeds a per-cycle scoreboard; each scenario task adds its own targeted checks.
module tb_test_pattern_checker;

    localparam int W  = 10;
    localparam int LC = 4;
    localparam int UC = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] d = '0;

    logic         locked, err, sticky;
    logic [15:0]  wc, ec;
    logic         locked2, err2, sticky2;
    logic [1:0]   wc2, ec2;

    always #5 clk = ~clk;

    test_pattern_checker #(.WIDTH(W), .LOCK_CNT(LC), .UNLOCK_CNT(UC), .CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_d(d), .i_clear(clear),
        .o_locked(locked), .o_err(err), .o_err_sticky(sticky),
        .o_word_count(wc), .o_err_count(ec)
    );

    test_pattern_checker #(.WIDTH(W), .LOCK_CNT(LC), .UNLOCK_CNT(UC), .CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_d(d), .i_clear(clear),
        .o_locked(locked2), .o_err(err2), .o_err_sticky(sticky2),
        .o_word_count(wc2), .o_err_count(ec2)
    );

    typedef struct {
        logic        locked;
        logic        err;
        logic        sticky;
        logic [15:0] wc;
        logic [15:0] ec;
        logic [1:0]  wc2;
        logic [1:0]  ec2;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic         m_locked, m_seeded, m_err, m_sticky;
    logic [W-1:0] m_exp;
    int           m_run, m_bad, m_words, m_errs;

    function automatic int cnt_exp(input int n, input int maxv);
`ifdef TPC_CNT_SAT_EN
        return (n > maxv) ? maxv : n;
`else
        return n % (maxv + 1);
`endif
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0; m_seeded = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
        m_exp = '0; m_run = 0; m_bad = 0; m_words = 0; m_errs = 0;
    endfunction

    function automatic void model_step(input logic v, input logic [W-1:0] dd, input logic c);
        m_err = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (!m_locked) begin
                if (m_seeded) begin
                    if (dd == m_exp) begin
                        if (m_run == LC - 1) begin
                            m_locked = 1'b1; m_bad = 0; m_run = 0;
                        end else begin
                            m_run++;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                m_seeded = 1'b1;
                m_exp = dd + 10'd1;
            end else begin
                m_words++;
                if (dd == m_exp) begin
                    m_bad = 0;
                end else begin
                    m_err = 1'b1; m_errs++; m_sticky = 1'b1;
                    if (m_bad == UC - 1) begin
                        m_locked = 1'b0; m_seeded = 1'b0; m_run = 0; m_bad = 0;
                    end else begin
                        m_bad++;
                    end
                end
                m_exp = m_exp + 10'd1;
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] dd, input logic c);
        exp_t e;
        @(negedge clk);
        valid = v; d = dd; clear = c;
        model_step(v, dd, c);
        e.locked = m_locked; e.err = m_err; e.sticky = m_sticky;
        e.wc  = 16'(cnt_exp(m_words, 65535));
        e.ec  = 16'(cnt_exp(m_errs, 65535));
        e.wc2 = 2'(cnt_exp(m_words, 3));
        e.ec2 = 2'(cnt_exp(m_errs, 3));
        sb_q.push_back(e);
        @(posedge clk);
        #2;
        valid = 1'b0; clear = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if ({locked, err, sticky, wc, ec, wc2, ec2} !==
                {e.locked, e.err, e.sticky, e.wc, e.ec, e.wc2, e.ec2}) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: got lk=%b er=%b st=%b wc=%0d ec=%0d wc2=%0d ec2=%0d, want lk=%b er=%b st=%b wc=%0d ec=%0d wc2=%0d ec2=%0d",
                         $time, locked, err, sticky, wc, ec, wc2, ec2,
                         e.locked, e.err, e.sticky, e.wc, e.ec, e.wc2, e.ec2);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({locked, err, sticky, wc, ec, locked2, err2, sticky2, wc2, ec2} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_state: got lk=%b er=%b st=%b wc=%0d ec=%0d, want all 0", locked, err, sticky, wc, ec);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(i), 1'b0);
            if (i == 3 || i == 4) begin
                vectors++;
                if (locked !== (i == 4)) begin
                    miscompares++;
                    $display("FAIL lock_edge word %0d: got %b want %b", i, locked, (i == 4));
                end
            end
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_no_err word %0d: got %b want 0", i, err);
            end
        end
        vectors++;
        if (wc !== 16'd5) begin
            miscompares++;
            $display("FAIL lock_word_count: got %0d want 5", wc);
        end
    endtask

    task automatic test_single_error();
        drive(1'b1, 10'd10, 1'b0);
        drive(1'b1, 10'd11, 1'b0);
        drive(1'b0, 10'd12, 1'b0);
        drive(1'b1, 10'd99, 1'b0);
        vectors++;
        if ({err, ec, sticky, locked} !== {1'b1, 16'd1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL single_err: got er=%b ec=%0d st=%b lk=%b want 1 1 1 1", err, ec, sticky, locked);
        end
        drive(1'b1, 10'd13, 1'b0);
        vectors++;
        if ({err, ec} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL single_err_pulse_end: got er=%b ec=%0d want 0 1", err, ec);
        end
        drive(1'b1, 10'd14, 1'b0);
        vectors++;
        if ({locked, wc} !== {1'b1, 16'd10}) begin
            miscompares++;
            $display("FAIL single_err_locked: got lk=%b wc=%0d want 1 10", locked, wc);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] seq [5];
        seq[0] = 10'd1021; seq[1] = 10'd1022; seq[2] = 10'd1023; seq[3] = 10'd0; seq[4] = 10'd1;
        drive(1'b0, 10'd0, 1'b1);
        for (int i = 1016; i <= 1020; i++) drive(1'b1, W'(i), 1'b0);
        vectors++;
        if ({locked, wc} !== {1'b1, 16'd0}) begin
            miscompares++;
            $display("FAIL wrap_lock: got lk=%b wc=%0d want 1 0", locked, wc);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_no_err word %0d: got %b want 0", seq[i], err);
            end
        end
        vectors++;
        if ({wc, ec} !== {16'd5, 16'd0}) begin
            miscompares++;
            $display("FAIL wrap_counts: got wc=%0d ec=%0d want 5 0", wc, ec);
        end
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'd500, 1'b0);
            vectors++;
            if ({locked, err} !== {(i < 2), 1'b1}) begin
                miscompares++;
                $display("FAIL unlock_bad %0d: got lk=%b er=%b want %b 1", i, locked, err, (i < 2));
            end
        end
        vectors++;
        if ({ec, wc} !== {16'd3, 16'd8}) begin
            miscompares++;
            $display("FAIL unlock_counts: got ec=%0d wc=%0d want 3 8", ec, wc);
        end
        for (int i = 50; i <= 54; i++) begin
            drive(1'b1, W'(i), 1'b0);
            if (i >= 53) begin
                vectors++;
                if (locked !== (i == 54)) begin
                    miscompares++;
                    $display("FAIL relock word %0d: got %b want %b", i, locked, (i == 54));
                end
            end
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b1, 10'd55, 1'b1);
        vectors++;
        if ({locked, err, sticky, wc, ec} !== 35'd0) begin
            miscompares++;
            $display("FAIL clear_outputs: got lk=%b er=%b st=%b wc=%0d ec=%0d want all 0", locked, err, sticky, wc, ec);
        end
        for (int i = 56; i <= 60; i++) begin
            drive(1'b1, W'(i), 1'b0);
            if (i >= 59) begin
                vectors++;
                if ({locked, wc} !== {(i == 60), 16'd0}) begin
                    miscompares++;
                    $display("FAIL clear_reseed word %0d: got lk=%b wc=%0d want %b 0", i, locked, wc, (i == 60));
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want_ec2, want_wc2;
`ifdef TPC_CNT_SAT_EN
        want_ec2 = 2'd3; want_wc2 = 2'd3;
`else
        want_ec2 = 2'd1; want_wc2 = 2'd2;
`endif
        drive(1'b0, 10'd0, 1'b1);
        for (int i = 0; i <= 4; i++) drive(1'b1, W'(i), 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, W'(5 + 2 * k), 1'b0);
            drive(1'b1, 10'd1000, 1'b0);
        end
        vectors++;
        if ({ec2, wc2, locked2, sticky2} !== {want_ec2, want_wc2, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL narrow_counters: got ec2=%0d wc2=%0d lk2=%b st2=%b want %0d %0d 1 1", ec2, wc2, locked2, sticky2, want_ec2, want_wc2);
        end
        vectors++;
        if ({ec, wc} !== {16'd5, 16'd10}) begin
            miscompares++;
            $display("FAIL wide_counters: got ec=%0d wc=%0d want 5 10", ec, wc);
        end
    endtask

    task automatic test_async_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({locked, err, sticky, wc, ec, locked2, err2, sticky2, wc2, ec2} !== 39'd0) begin
            miscompares++;
            $display("FAIL async_reset: got lk=%b st=%b wc=%0d ec=%0d lk2=%b wc2=%0d ec2=%0d want all 0",
                     locked, sticky, wc, ec, locked2, wc2, ec2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 200; i <= 204; i++) begin
            drive(1'b1, W'(i), 1'b0);
            if (i >= 203) begin
                vectors++;
                if (locked !== (i == 204)) begin
                    miscompares++;
                    $display("FAIL post_reset_relock word %0d: got %b want %b", i, locked, (i == 204));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_wrap();
        test_unlock();
        test_clear_priority();
        test_saturation();
        test_async_reset();
        repeat (2) @(posedge clk);
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
